// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALUFun codes, opcode/funct constants, select encodings and the decoded bundle type
package alu_ctrl_pkg;

  // ALUFun encoding consumed by the ALU
  typedef enum logic [5:0] {
    ALU_ADD   = 6'b000000,
    ALU_SUB   = 6'b000001,
    ALU_AND   = 6'b011000,
    ALU_OR    = 6'b011110,
    ALU_XOR   = 6'b010110,
    ALU_NOR   = 6'b010001,
    ALU_PASSA = 6'b011010,
    ALU_SLL   = 6'b100000,
    ALU_SRL   = 6'b100001,
    ALU_SRA   = 6'b100011,
    ALU_EQ    = 6'b110011,
    ALU_NEQ   = 6'b110001,
    ALU_LT    = 6'b110101,
    ALU_LEZ   = 6'b111101,
    ALU_LTZ   = 6'b111011,
    ALU_GTZ   = 6'b111111
  } alu_fun_e;

  // Primary opcodes (instr[31:26])
  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07,
    OP_ADDI   = 6'h08,
    OP_ADDIU  = 6'h09,
    OP_SLTI   = 6'h0A,
    OP_SLTIU  = 6'h0B,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E,
    OP_LUI    = 6'h0F,
    OP_LW     = 6'h23,
    OP_SW     = 6'h2B
  } opcode_e;

  // R-type function codes (instr[5:0])
  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_SRAV = 6'h07,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  // Operand A source: register rs, zero-extended shamt, or the constant 16 (lui)
  localparam logic [1:0] SRC_A_RS    = 2'd0;
  localparam logic [1:0] SRC_A_SHAMT = 2'd1;
  localparam logic [1:0] SRC_A_C16   = 2'd2;

  // Operand B source: register rt or the extended immediate
  localparam logic SRC_B_RT  = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // Everything the decode stage hands to the ALU/datapath for one instruction
  typedef struct packed {
    alu_fun_e    alu_fun;
    logic        alu_sign;
    logic [1:0]  src_a_sel;
    logic        src_b_sel;
    logic [31:0] imm32;
    logic [4:0]  wr_reg;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_branch;
    logic        illegal;
  } dec_bundle_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec_if.sv
// rtl/alu_ctrl_dec_if.sv - instruction-in / decoded-bundle-out handshake bus of the decode stage
interface alu_ctrl_dec_if #(
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       alu_fun;
  logic             alu_sign;
  logic [1:0]       src_a_sel;
  logic             src_b_sel;
  logic [31:0]      imm32;
  logic [4:0]       wr_reg;
  logic             reg_wr;
  logic             mem_rd;
  logic             mem_wr;
  logic             is_branch;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  // Fetch side / consumer side driving the stage
  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_fun, alu_sign, src_a_sel, src_b_sel, imm32,
           wr_reg, reg_wr, mem_rd, mem_wr, is_branch, illegal, illegal_cnt
  );

  // The decode stage itself
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_fun, alu_sign, src_a_sel, src_b_sel, imm32,
           wr_reg, reg_wr, mem_rd, mem_wr, is_branch, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational MIPS instruction to ALU control bundle; branches decoded only with ALU_CTRL_BRANCH_EN
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_bundle_t o_bundle
);

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [5:0]  w_funct;
  logic        w_ill;
  logic        w_unused_rs;

  assign w_op        = i_instr[31:26];
  assign w_rt        = i_instr[20:16];
  assign w_rd        = i_instr[15:11];
  assign w_imm       = i_instr[15:0];
  assign w_funct     = i_instr[5:0];
  // rs only feeds the register file read port, never the control bundle
  assign w_unused_rs = ^i_instr[25:21];

  // Decode opcode/funct into the bundle; any unsupported encoding collapses to a clean illegal bundle
  always_comb begin
    o_bundle         = '0;
    o_bundle.alu_fun = ALU_ADD;
    o_bundle.imm32   = sext16(w_imm);
    w_ill            = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        o_bundle.wr_reg = w_rd;
        o_bundle.reg_wr = 1'b1;
        case (w_funct)
          FN_ADD:  begin o_bundle.alu_fun = ALU_ADD; o_bundle.alu_sign = 1'b1; end
          FN_ADDU: o_bundle.alu_fun = ALU_ADD;
          FN_SUB:  begin o_bundle.alu_fun = ALU_SUB; o_bundle.alu_sign = 1'b1; end
          FN_SUBU: o_bundle.alu_fun = ALU_SUB;
          FN_AND:  o_bundle.alu_fun = ALU_AND;
          FN_OR:   o_bundle.alu_fun = ALU_OR;
          FN_XOR:  o_bundle.alu_fun = ALU_XOR;
          FN_NOR:  o_bundle.alu_fun = ALU_NOR;
          FN_SLT:  begin o_bundle.alu_fun = ALU_LT; o_bundle.alu_sign = 1'b1; end
          FN_SLTU: o_bundle.alu_fun = ALU_LT;
          FN_SLL:  begin o_bundle.alu_fun = ALU_SLL; o_bundle.src_a_sel = SRC_A_SHAMT; end
          FN_SRL:  begin o_bundle.alu_fun = ALU_SRL; o_bundle.src_a_sel = SRC_A_SHAMT; end
          FN_SRA:  begin o_bundle.alu_fun = ALU_SRA; o_bundle.src_a_sel = SRC_A_SHAMT; end
          FN_SLLV: o_bundle.alu_fun = ALU_SLL;
          FN_SRLV: o_bundle.alu_fun = ALU_SRL;
          FN_SRAV: o_bundle.alu_fun = ALU_SRA;
          default: w_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        o_bundle.alu_fun   = ALU_ADD;
        o_bundle.alu_sign  = (w_op == OP_ADDI);
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.wr_reg    = w_rt;
        o_bundle.reg_wr    = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        o_bundle.alu_fun   = ALU_LT;
        o_bundle.alu_sign  = (w_op == OP_SLTI);
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.wr_reg    = w_rt;
        o_bundle.reg_wr    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_bundle.alu_fun   = (w_op == OP_ANDI) ? ALU_AND :
                             (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.imm32     = zext16(w_imm);
        o_bundle.wr_reg    = w_rt;
        o_bundle.reg_wr    = 1'b1;
      end
      OP_LUI: begin
        // lui is imm << 16, done on the shifter with a constant shift amount
        o_bundle.alu_fun   = ALU_SLL;
        o_bundle.src_a_sel = SRC_A_C16;
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.imm32     = zext16(w_imm);
        o_bundle.wr_reg    = w_rt;
        o_bundle.reg_wr    = 1'b1;
      end
      OP_LW: begin
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.wr_reg    = w_rt;
        o_bundle.reg_wr    = 1'b1;
        o_bundle.mem_rd    = 1'b1;
      end
      OP_SW: begin
        o_bundle.src_b_sel = SRC_B_IMM;
        o_bundle.wr_reg    = w_rt;
        o_bundle.mem_wr    = 1'b1;
      end
`ifdef ALU_CTRL_BRANCH_EN
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        o_bundle.alu_fun   = (w_op == OP_BEQ)  ? ALU_EQ  :
                             (w_op == OP_BNE)  ? ALU_NEQ :
                             (w_op == OP_BLEZ) ? ALU_LEZ : ALU_GTZ;
        o_bundle.alu_sign  = 1'b1;
        o_bundle.is_branch = 1'b1;
      end
      OP_REGIMM: begin
        // Only bltz (rt == 0) of the REGIMM group is supported
        if (w_rt == 5'd0) begin
          o_bundle.alu_fun   = ALU_LTZ;
          o_bundle.alu_sign  = 1'b1;
          o_bundle.is_branch = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
`endif
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      o_bundle         = '0;
      o_bundle.alu_fun = ALU_ADD;
      o_bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - registered decode stage with 1-entry skid buffer and illegal counter; ALU_CTRL_BRANCH_EN enables branches
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  alu_ctrl_dec_if.slave bus
);

  dec_bundle_t      w_dec;
  dec_bundle_t      r_out;
  dec_bundle_t      r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_illegal_cnt;
  logic             w_accept;
  logic             w_out_load;

  alu_ctrl_decode u_decode (
    .i_instr  (bus.in_instr),
    .o_bundle (w_dec)
  );

  // in_ready depends only on the skid register, never on out_ready
  assign w_accept   = bus.in_valid & ~r_skid_valid;
  assign w_out_load = ~r_out_valid | bus.out_ready;

  // Output register and skid buffer: output refills from skid first, so order is preserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid <= w_dec;
        end
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out <= w_dec;
        end
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  // Saturating count of accepted illegal words; a flush does not take back an acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = ~r_skid_valid;
  assign bus.out_valid   = r_out_valid;
  assign bus.alu_fun     = r_out.alu_fun;
  assign bus.alu_sign    = r_out.alu_sign;
  assign bus.src_a_sel   = r_out.src_a_sel;
  assign bus.src_b_sel   = r_out.src_b_sel;
  assign bus.imm32       = r_out.imm32;
  assign bus.wr_reg      = r_out.wr_reg;
  assign bus.reg_wr      = r_out.reg_wr;
  assign bus.mem_rd      = r_out.mem_rd;
  assign bus.mem_wr      = r_out.mem_wr;
  assign bus.illegal     = r_out.illegal;
  assign bus.illegal_cnt = r_illegal_cnt;

`ifdef ALU_CTRL_BRANCH_EN
  assign bus.is_branch = r_out.is_branch;
`else
  logic w_unused_branch;
  assign w_unused_branch = r_out.is_branch;
  assign bus.is_branch   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_dec.sv
// tb/tb_alu_ctrl_dec.sv - directed bench for alu_ctrl_dec (both ALU_CTRL_BRANCH_EN builds)
module tb_alu_ctrl_dec;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   exp_cnt;

  alu_ctrl_dec_if #(.CNT_W(CNT_W)) bus ();

  alu_ctrl_dec #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] mk(input logic [5:0] fun, input logic sign, input logic [1:0] a,
                                     input logic b, input logic [31:0] imm, input logic [4:0] wr,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic br, input logic ill);
    return {fun, sign, a, b, imm, wr, rw, mr, mw, br, ill};
  endfunction

  function automatic logic [51:0] obs_bundle();
    return {bus.alu_fun, bus.alu_sign, bus.src_a_sel, bus.src_b_sel, bus.imm32, bus.wr_reg,
            bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.is_branch, bus.illegal};
  endfunction

  function automatic int sat_inc(input int c);
    return (c < (1 << CNT_W) - 1) ? c + 1 : c;
  endfunction

  // One word through an idle stage with out_ready high; bundle must appear one edge later
  task automatic send_chk(input string tag, input logic [31:0] instr, input logic [51:0] exp);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (exp[0]) exp_cnt = sat_inc(exp_cnt);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check(tag, {12'd0, obs_bundle()}, {12'd0, exp});
    check({tag, "_cnt"}, {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'(exp_cnt));
  endtask

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [51:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [51:0] e_ill;
  logic [51:0] e_add;
  logic [51:0] e_lui;
  logic [51:0] e_andi;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b0;

    e_ill  = mk(6'b000000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    e_add  = mk(6'b000000, 1, 0, 0, 32'h00001820, 3, 1, 0, 0, 0, 0);
    e_lui  = mk(6'b100000, 0, 2, 1, 32'h00001234, 5, 1, 0, 0, 0, 0);
    e_andi = mk(6'b011000, 0, 0, 1, 32'h0000FFFF, 4, 1, 0, 0, 0, 0);

    vecs.push_back('{"add",  32'h00221820, e_add});
    vecs.push_back('{"lui",  32'h3C051234, e_lui});
    vecs.push_back('{"andi", 32'h3084FFFF, e_andi});
    vecs.push_back('{"addi", 32'h2084FFFF, mk(6'b000000, 1, 0, 1, 32'hFFFFFFFF, 4, 1, 0, 0, 0, 0)});
    vecs.push_back('{"sra",  32'h00031103, mk(6'b100011, 0, 1, 0, 32'h00001103, 2, 1, 0, 0, 0, 0)});
    vecs.push_back('{"sltu", 32'h0022382B, mk(6'b110101, 0, 0, 0, 32'h0000382B, 7, 1, 0, 0, 0, 0)});
    vecs.push_back('{"nor",  32'h00225027, mk(6'b010001, 0, 0, 0, 32'h00005027, 10, 1, 0, 0, 0, 0)});
    vecs.push_back('{"lw",   32'h8FA8FFFC, mk(6'b000000, 0, 0, 1, 32'hFFFFFFFC, 8, 1, 1, 0, 0, 0)});
    vecs.push_back('{"sw",   32'hAFA80008, mk(6'b000000, 0, 0, 1, 32'h00000008, 8, 0, 0, 1, 0, 0)});
    vecs.push_back('{"slti", 32'h2829FFFF, mk(6'b110101, 1, 0, 1, 32'hFFFFFFFF, 9, 1, 0, 0, 0, 0)});
    vecs.push_back('{"xori", 32'h38418001, mk(6'b010110, 0, 0, 1, 32'h00008001, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{"jr",   32'h03E00008, e_ill});
`ifdef ALU_CTRL_BRANCH_EN
    vecs.push_back('{"beq",  32'h10220004, mk(6'b110011, 1, 0, 0, 32'h00000004, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{"bltz", 32'h04200003, mk(6'b111011, 1, 0, 0, 32'h00000003, 0, 0, 0, 0, 1, 0)});
`else
    vecs.push_back('{"beq",  32'h10220004, e_ill});
    vecs.push_back('{"bltz", 32'h04200003, e_ill});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_bundle", {12'd0, obs_bundle()}, 64'd0);
    check("rst_cnt", {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'd0);
    reset = 1'b0;

    // Single-word decode vectors
    foreach (vecs[i]) send_chk(vecs[i].tag, vecs[i].instr, vecs[i].exp);
    @(negedge clk);
    check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Stall: three words offered with out_ready low, only two taken
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00221820;
    @(negedge clk);
    check("stall_rdy1", {63'd0, bus.in_ready}, 64'd1);
    bus.in_instr = 32'h3C051234;
    @(negedge clk);
    check("stall_rdy2", {63'd0, bus.in_ready}, 64'd0);
    bus.in_instr = 32'h3084FFFF;
    @(negedge clk);
    check("stall_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    check("stall_hold_a", {12'd0, obs_bundle()}, {12'd0, e_add});
    check("stall_rdy3", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_b", {12'd0, obs_bundle()}, {12'd0, e_lui});
    check("drain_rdy", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("drain_c", {12'd0, obs_bundle()}, {12'd0, e_andi});
    check("drain_c_valid", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    check("drain_empty", {63'd0, bus.out_valid}, 64'd0);

    // Illegal stream drives the counter into saturation
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFC000000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_cnt = sat_inc(exp_cnt);
    end
    bus.in_valid = 1'b0;
    check("sat_cnt", {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'(exp_cnt));
    check("sat_all_ones", {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'((1 << CNT_W) - 1));
    @(negedge clk);

    // Flush mid-stall drops output, skid and the same-cycle input
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00221820;
    @(negedge clk);
    bus.in_instr = 32'h3C051234;
    @(negedge clk);
    check("pre_flush_rdy", {63'd0, bus.in_ready}, 64'd0);
    bus.flush    = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_instr = 32'h3084FFFF;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush_rdy", {63'd0, bus.in_ready}, 64'd1);
    check("flush_cnt", {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'(exp_cnt));
    @(negedge clk);
    check("flush_dropped", {63'd0, bus.out_valid}, 64'd0);

    // Asynchronous reset in the middle of a stalled transfer
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00221820;
    @(negedge clk);
    bus.in_instr = 32'h3C051234;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_rdy", {63'd0, bus.in_ready}, 64'd1);
    check("arst_cnt", {{(64-CNT_W){1'b0}}, bus.illegal_cnt}, 64'(exp_cnt));
    check("arst_bundle", {12'd0, obs_bundle()}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send_chk("post_rst_add", 32'h00221820, e_add);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
